combo_counter: RTL and testbench



---
 rtl/combo_pkg.sv | 19 +
 rtl/rise_edge_detect.sv | 24 ++
 rtl/combo_counter.sv | 91 +++++++++
 tb/tb_combo_counter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/combo_pkg.sv
// Shared defaults and the per-clock update action for the combo counter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package combo_pkg;

    localparam int DEF_COUNT_W        = 7;
    localparam int DEF_MAX_COMBO      = 99;
    localparam int DEF_HIT_INC        = 1;
    localparam int DEF_FULL_CLEAR_INC = 2;

    // What the count register does on a given clock, already priority-resolved.
    typedef enum logic [1:0] {
        ACT_HOLD     = 2'd0,
        ACT_CLEAR    = 2'd1,
        ACT_ADD_HIT  = 2'd2,
        ACT_ADD_FULL = 2'd3
    } action_t;

endpackage

// File: rtl/rise_edge_detect.sv
// Turns a level into a one-clock pulse on its rising edge.
// Latency: pulse is combinational from d (same cycle the level is first seen high).
// Backpressure: none; a level held high yields exactly one pulse.
module rise_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic prev;

    // History bit; cleared on reset so a level already high at release counts once.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= d;
        end
    end

    assign pulse = d & ~prev;

endmodule

// File: rtl/combo_counter.sv
// Saturating hit-streak counter driven by edge-qualified hit/miss levels.
// Latency: combo_count updates on the edge that first samples an input high.
// Backpressure: none; events are consumed every clock, miss beats any hit.
module combo_counter
    import combo_pkg::*;
#(
    parameter int COUNT_W        = DEF_COUNT_W,
    parameter int MAX_COMBO      = DEF_MAX_COMBO,
    parameter int HIT_INC        = DEF_HIT_INC,
    parameter int FULL_CLEAR_INC = DEF_FULL_CLEAR_INC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               miss,
    input  logic               non_full_clear_hit,
    input  logic               full_clear_hit,
    output logic [COUNT_W-1:0] combo_count
);

    localparam logic [COUNT_W:0] MAX_W  = (COUNT_W+1)'(MAX_COMBO);
    localparam logic [COUNT_W:0] HIT_W  = (COUNT_W+1)'(HIT_INC);
    localparam logic [COUNT_W:0] FULL_W = (COUNT_W+1)'(FULL_CLEAR_INC);

    logic             ev_miss;
    logic             ev_hit;
    logic             ev_full;
    action_t          action;
    logic [COUNT_W:0] inc;
    logic [COUNT_W:0] sum;
    logic [COUNT_W:0] sat_sum;

    rise_edge_detect u_miss_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (miss),
        .pulse (ev_miss)
    );

    rise_edge_detect u_hit_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (non_full_clear_hit),
        .pulse (ev_hit)
    );

    rise_edge_detect u_full_edge (
        .clk   (clk),
        .rst   (rst),
        .d     (full_clear_hit),
        .pulse (ev_full)
    );

    // Priority: a miss wipes the streak; a full clear wins over a plain hit (no stacking).
    always_comb begin
        action = ACT_HOLD;
        if (ev_miss) begin
            action = ACT_CLEAR;
        end else if (ev_full) begin
            action = ACT_ADD_FULL;
        end else if (ev_hit) begin
            action = ACT_ADD_HIT;
        end
    end

    // One extra bit on the sum so the ceiling compare never sees a wrapped value.
    always_comb begin
        inc = '0;
        if (action == ACT_ADD_FULL) begin
            inc = FULL_W;
        end else if (action == ACT_ADD_HIT) begin
            inc = HIT_W;
        end
        sum     = {1'b0, combo_count} + inc;
        sat_sum = (sum > MAX_W) ? MAX_W : sum;
    end

    // Count register; reset drops any event seen in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            combo_count <= '0;
        end else begin
            case (action)
                ACT_CLEAR:    combo_count <= '0;
                ACT_ADD_HIT,
                ACT_ADD_FULL: combo_count <= sat_sum[COUNT_W-1:0];
                default:      combo_count <= combo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_combo_counter.sv
// Self-checking bench for combo_counter: directed scenarios plus random traffic
// checked against an event-level reference model of the streak rules.
// Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
module tb_combo_counter;

    logic       clk;
    logic       rst;
    logic       miss;
    logic       non_full_clear_hit;
    logic       full_clear_hit;
    logic [6:0] combo_count;

    int errors;
    int checks;

    // Reference model state: streak value and the last level seen on each input.
    int m_count;
    bit m_last_miss;
    bit m_last_hit;
    bit m_last_full;

    combo_counter dut (
        .clk                (clk),
        .rst                (rst),
        .miss               (miss),
        .non_full_clear_hit (non_full_clear_hit),
        .full_clear_hit     (full_clear_hit),
        .combo_count        (combo_count)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Applies one clock of stimulus and advances the reference model.
    task automatic step(input bit m, input bit h, input bit f, input bit r);
        bit new_miss, new_hit, new_full;
        @(negedge clk);
        miss               = m;
        non_full_clear_hit = h;
        full_clear_hit     = f;
        rst                = r;
        @(posedge clk);
        if (r) begin
            m_count     = 0;
            m_last_miss = 0;
            m_last_hit  = 0;
            m_last_full = 0;
        end else begin
            new_miss = m && !m_last_miss;
            new_hit  = h && !m_last_hit;
            new_full = f && !m_last_full;
            if (new_miss)      m_count = 0;
            else if (new_full) m_count = (m_count + 2 > 99) ? 99 : m_count + 2;
            else if (new_hit)  m_count = (m_count + 1 > 99) ? 99 : m_count + 1;
            m_last_miss = m;
            m_last_hit  = h;
            m_last_full = f;
        end
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        exp = 7'd0;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL reset_value: got %0d expected %0d", combo_count, exp);
        end
    endtask

    task automatic test_hits();
        logic [6:0] exp;
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        exp = 7'd1;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL hit_first: got %0d expected %0d", combo_count, exp);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        exp = 7'd2;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL hit_second: got %0d expected %0d", combo_count, exp);
        end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        exp = 7'd4;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL full_first: got %0d expected %0d", combo_count, exp);
        end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        exp = 7'd6;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL full_second: got %0d expected %0d", combo_count, exp);
        end
        step(1, 0, 0, 0);
        exp = 7'd0;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL miss_clear: got %0d expected %0d", combo_count, exp);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        logic [6:0] exp;
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(1, 0, 1, 0);
        exp = 7'd0;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL miss_with_full: got %0d expected %0d", combo_count, exp);
        end
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        exp = 7'd0;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL miss_with_hit: got %0d expected %0d", combo_count, exp);
        end
        step(0, 0, 0, 0);
        step(0, 1, 1, 0);
        exp = 7'd2;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL full_with_hit: got %0d expected %0d", combo_count, exp);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_held_and_reset();
        logic [6:0] exp;
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        exp = 7'd4;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL full_held: got %0d expected %0d", combo_count, exp);
        end
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
        exp = 7'd0;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL reset_midstreak: got %0d expected %0d", combo_count, exp);
        end
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        exp = 7'd1;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL hit_at_release: got %0d expected %0d", combo_count, exp);
        end
        // Level already high during reset still counts once after release.
        step(0, 0, 1, 1);
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        exp = 7'd2;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL high_through_reset: got %0d expected %0d", combo_count, exp);
        end
        step(0, 0, 0, 0);
    endtask

    task automatic test_saturation();
        logic [6:0] exp;
        int over;
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        over = 0;
        for (int i = 0; i < 60; i++) begin
            step(0, 0, 1, 0);
            if (combo_count > 7'd99) over++;
            step(0, 0, 0, 0);
        end
        checks++;
        if (over != 0) begin
            errors++;
            $display("FAIL sat_never_above: got %0d cycles above 99 expected 0", over);
        end
        exp = 7'd99;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL sat_full: got %0d expected %0d", combo_count, exp);
        end
        step(0, 1, 0, 0);
        step(0, 0, 0, 0);
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL sat_hit: got %0d expected %0d", combo_count, exp);
        end
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        exp = 7'd0;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL sat_miss: got %0d expected %0d", combo_count, exp);
        end
    endtask

    task automatic test_reset_with_hit();
        logic [6:0] exp;
        int bad;
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 1);
        exp = 7'd0;
        checks++;
        if (combo_count !== exp) begin
            errors++;
            $display("FAIL reset_drops_event: got %0d expected %0d", combo_count, exp);
        end
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0);
            if (combo_count !== 7'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL after_reset_idle: got %0d nonzero cycles expected 0", bad);
        end
    endtask

    task automatic test_random();
        bit m, h, f, r;
        for (int i = 0; i < 1500; i++) begin
            m = ($urandom_range(0, 24) == 0);
            h = ($urandom_range(0, 2) == 0);
            f = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 199) == 0);
            step(m, h, f, r);
            checks++;
            if (combo_count !== 7'(m_count)) begin
                errors++;
                $display("FAIL random_cycle_%0d: got %0d expected %0d", i, combo_count, m_count);
            end
        end
    endtask

    initial begin
        errors             = 0;
        checks             = 0;
        m_count            = 0;
        m_last_miss        = 0;
        m_last_hit         = 0;
        m_last_full        = 0;
        rst                = 1'b1;
        miss               = 1'b0;
        non_full_clear_hit = 1'b0;
        full_clear_hit     = 1'b0;

        test_reset();
        test_hits();
        test_simultaneous();
        test_held_and_reset();
        test_saturation();
        test_reset_with_hit();
        test_random();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
